sbox_scheduler: RTL and testbench

SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/sbox.sv | 14 +
 rtl/sbox_scheduler_bank.sv | 20 ++
 rtl/sbox_scheduler.sv | 123 ++++++++++++
 tb/tb_sbox_scheduler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the S-box scheduler slice.
// Contents:
//   - bus widths and bank geometry (SBOX_LANES lanes, SB_BEATS beats per full state)
//   - scheduler FSM state enum
//   - GF(2^8) helper functions and the byte S-box function used by the sbox cell
package aes_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int STATE_W    = 128;
  localparam int SBOX_LANES = 4;
  localparam int SB_BEATS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SB   = 2'd1,
    ST_KW   = 2'd2,
    ST_ACK  = 2'd3
  } sched_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // AES forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sbox.sv
// Single combinational AES S-box cell.
// Ports:
//   din  [7:0]  byte to substitute
//   dout [7:0]  substituted byte
module sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  assign dout = sbox_byte(din);

endmodule

// File: rtl/sbox_scheduler_bank.sv
// Four-lane S-box bank: one 32-bit word substituted per cycle, purely combinational.
// This is the only S-box hardware in the scheduler; both requesters share it.
// Ports:
//   lane_in  [31:0]  word to substitute (byte g feeds lane g)
//   lane_out [31:0]  substituted word
module sbox_bank
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] lane_in,
  output logic [WORD_W-1:0] lane_out
);

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    sbox u_sbox (
      .din  (lane_in[g*BYTE_W +: BYTE_W]),
      .dout (lane_out[g*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: rtl/sbox_scheduler.sv
// Time-shares one 4-lane S-box bank between the round datapath (full-state
// SubBytes, 4 beats) and key expansion (SubWord, 1 beat).
// Ports:
//   clk, rst_n               clock, async active-low reset
//   sb_req, sb_state_in      SubBytes request (level) and 128-bit state
//   sb_ack, sb_state_out     one-cycle completion pulse and registered result
//   kw_req, kw_word_in       SubWord request (level) and 32-bit word
//   kw_ack, kw_word_out      one-cycle completion pulse and registered result
//   busy                     high whenever the FSM is not idle
// RR_ENABLE: 1 = alternate on a tie, 0 = key word always wins a tie.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sb_req,
  input  logic [STATE_W-1:0] sb_state_in,
  output logic               sb_ack,
  output logic [STATE_W-1:0] sb_state_out,
  input  logic               kw_req,
  input  logic [WORD_W-1:0]  kw_word_in,
  output logic               kw_ack,
  output logic [WORD_W-1:0]  kw_word_out,
  output logic               busy
);

  sched_state_e      state_r, state_s;
  logic [1:0]        beat_r, beat_s;
  logic              last_sb_r, last_sb_s;  // 1 = last completed grant went to sb
  logic [WORD_W-1:0] lane_in_s;
  logic [WORD_W-1:0] lane_out_s;

  sbox_bank u_bank (
    .lane_in  (lane_in_s),
    .lane_out (lane_out_s)
  );

  // Bank input mux: current SubBytes word during SB, otherwise the key word.
  always_comb begin
    lane_in_s = kw_word_in;
    if (state_r == ST_SB) lane_in_s = sb_state_in[{beat_r, 5'd0} +: WORD_W];
    else                  lane_in_s = kw_word_in;
  end

  // Next-state logic, arbitration and last-grant bookkeeping.
  always_comb begin
    state_s   = state_r;
    beat_s    = beat_r;
    last_sb_s = last_sb_r;
    case (state_r)
      ST_IDLE: begin
        beat_s = 2'd0;
        if (sb_req && kw_req) begin
          // A tie goes to sb only when alternating and kw was served last.
          if (RR_ENABLE && !last_sb_r) state_s = ST_SB;
          else                         state_s = ST_KW;
        end else if (sb_req) begin
          state_s = ST_SB;
        end else if (kw_req) begin
          state_s = ST_KW;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SB: begin
        if (beat_r == 2'd3) begin
          state_s   = ST_ACK;
          beat_s    = 2'd0;
          last_sb_s = 1'b1;
        end else begin
          beat_s = beat_r + 2'd1;
        end
      end
      ST_KW: begin
        state_s   = ST_ACK;
        last_sb_s = 1'b0;
      end
      ST_ACK: begin
        // Requests are ignored here; arbitration resumes from IDLE.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        beat_s  = 2'd0;
      end
    endcase
  end

  // FSM state, beat counter and last-grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      beat_r    <= 2'd0;
      last_sb_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      beat_r    <= beat_s;
      last_sb_r <= last_sb_s;
    end
  end

  // Registered outputs: acks fire in the ACK cycle, results land beat by beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_ack       <= 1'b0;
      kw_ack       <= 1'b0;
      busy         <= 1'b0;
      sb_state_out <= {STATE_W{1'b0}};
      kw_word_out  <= {WORD_W{1'b0}};
    end else begin
      sb_ack <= (state_r == ST_SB) && (beat_r == 2'd3);
      kw_ack <= (state_r == ST_KW);
      busy   <= (state_s != ST_IDLE);
      if (state_r == ST_SB) sb_state_out[{beat_r, 5'd0} +: WORD_W] <= lane_out_s;
      else                  sb_state_out <= sb_state_out;
      if (state_r == ST_KW) kw_word_out <= lane_out_s;
      else                  kw_word_out <= kw_word_out;
    end
  end

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler: directed vectors plus randomized
// request traffic checked against a transaction-level reference model.
module tb_sbox_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sb_req, kw_req;
  logic [127:0] sb_state_in;
  logic [31:0]  kw_word_in;
  logic         sb_ack, kw_ack, busy;
  logic [127:0] sb_state_out;
  logic [31:0]  kw_word_out;

  // Second instance with fixed-priority tie-break.
  logic         f_sb_req, f_kw_req;
  logic [127:0] f_sb_state_in;
  logic [31:0]  f_kw_word_in;
  logic         f_sb_ack, f_kw_ack, f_busy;
  logic [127:0] f_sb_state_out;
  logic [31:0]  f_kw_word_out;

  sbox_scheduler #(.RR_ENABLE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .sb_req(sb_req), .sb_state_in(sb_state_in), .sb_ack(sb_ack), .sb_state_out(sb_state_out),
    .kw_req(kw_req), .kw_word_in(kw_word_in), .kw_ack(kw_ack), .kw_word_out(kw_word_out),
    .busy(busy)
  );

  sbox_scheduler #(.RR_ENABLE(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .sb_req(f_sb_req), .sb_state_in(f_sb_state_in), .sb_ack(f_sb_ack), .sb_state_out(f_sb_state_out),
    .kw_req(f_kw_req), .kw_word_in(f_kw_word_in), .kw_ack(f_kw_ack), .kw_word_out(f_kw_word_out),
    .busy(f_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference S-box from first principles: brute-force inverse, then affine map.
  int ref_sbox [256];

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) == 1) p = p ^ ('h11b << (i - 8));
    return p;
  endfunction

  task automatic build_ref();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      for (int i = 0; i < 8; i++) begin
        int v;
        v = ((inv >> i) & 1) ^ ((inv >> ((i + 4) % 8)) & 1) ^ ((inv >> ((i + 5) % 8)) & 1) ^
            ((inv >> ((i + 6) % 8)) & 1) ^ ((inv >> ((i + 7) % 8)) & 1) ^ (('h63 >> i) & 1);
        s = s | (v << i);
      end
      ref_sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input int nbytes);
    logic [127:0] r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = 8'(ref_sbox[int'(d[8*i +: 8])]);
    return r;
  endfunction

  // Transaction model: op 0 = none, 1 = sb, 2 = kw; cyc counts cycles since grant.
  int           m_op;
  int           m_cyc;
  bit           m_last_sb;
  logic [127:0] m_sb_exp;
  logic [31:0]  m_kw_exp;

  function automatic int lat(input int op);
    return (op == 1) ? 5 : 2;
  endfunction

  task automatic model_reset();
    m_op = 0; m_cyc = 0; m_last_sb = 1'b1;
  endtask

  // Advance the model across one rising edge using the inputs presented now.
  task automatic model_step();
    int g;
    if (!rst_n) begin
      model_reset();
    end else if (m_op != 0) begin
      if (m_cyc == lat(m_op)) begin
        m_last_sb = (m_op == 1);
        m_op = 0;
      end else begin
        m_cyc++;
      end
    end else begin
      g = 0;
      if (sb_req && kw_req) g = m_last_sb ? 2 : 1;
      else if (sb_req)      g = 1;
      else if (kw_req)      g = 2;
      if (g != 0) begin
        m_op = g; m_cyc = 1;
        if (g == 1) m_sb_exp = ref_sub(sb_state_in, 16);
        else        m_kw_exp = ref_sub({96'd0, kw_word_in}, 4)[31:0];
      end
    end
  endtask

  function automatic bit exp_sb_ack(); return (m_op == 1) && (m_cyc == 5); endfunction
  function automatic bit exp_kw_ack(); return (m_op == 2) && (m_cyc == 2); endfunction

  task automatic compare_outputs();
    check_val("sb_ack", 128'(sb_ack), 128'(exp_sb_ack()));
    check_val("kw_ack", 128'(kw_ack), 128'(exp_kw_ack()));
    check_val("busy", 128'(busy), 128'(m_op != 0));
    if (exp_sb_ack()) check_val("sb_data", sb_state_out, m_sb_exp);
    if (exp_kw_ack()) check_val("kw_data", 128'(kw_word_out), 128'(m_kw_exp));
  endtask

  // One clock: predict the edge, let it pass, compare on the falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_req = 1'b0; kw_req = 1'b0; f_sb_req = 1'b0; f_kw_req = 1'b0;
    #1;
    model_reset();
    check_val("rst_sb_out", sb_state_out, 128'd0);
    check_val("rst_kw_out", 128'(kw_word_out), 128'd0);
    check_val("rst_sb_ack", 128'(sb_ack), 128'd0);
    check_val("rst_kw_ack", 128'(kw_ack), 128'd0);
    check_val("rst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sb_at, kw_at, f_kw_n, f_sb_n, n_ord;
    int ord [4];
    rst_n = 1'b0;
    sb_req = 1'b0; kw_req = 1'b0; sb_state_in = '0; kw_word_in = '0;
    f_sb_req = 1'b0; f_kw_req = 1'b0; f_sb_state_in = '0; f_kw_word_in = '0;
    build_ref();
    model_reset();
    #2;
    do_reset();

    // Known SubBytes vector, ack in cycle 5.
    sb_state_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    sb_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("sb_vec_ack", 128'(sb_ack), 128'd1);
    check_val("sb_vec_data", sb_state_out, 128'hd42711aee0bf98f1b8b45de51e415230);
    sb_req = 1'b0;
    tick();

    // Known SubWord vectors, ack in cycle 2; second request presented right after the ack.
    kw_word_in = 32'hcf4f3c09; kw_req = 1'b1;
    tick(); tick();
    check_val("kw_vec_ack", 128'(kw_ack), 128'd1);
    check_val("kw_vec_data", 128'(kw_word_out), 128'(32'h8a84eb01));
    kw_word_in = 32'h00000000;
    tick(); tick(); tick();
    check_val("kw_zero_ack", 128'(kw_ack), 128'd1);
    check_val("kw_zero_data", 128'(kw_word_out), 128'(32'h63636363));
    kw_req = 1'b0;
    tick();

    // kw raised during SB beat 1 waits; kw_ack 3 cycles after sb_ack.
    sb_state_in = {$urandom, $urandom, $urandom, $urandom}; sb_req = 1'b1;
    tick(); tick();
    kw_word_in = $urandom; kw_req = 1'b1;
    sb_at = -1; kw_at = -1;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (sb_ack && sb_at < 0) sb_at = t;
      if (kw_ack && kw_at < 0) kw_at = t;
      if (sb_ack) sb_req = 1'b0;
      if (kw_ack) kw_req = 1'b0;
    end
    check_val("mid_sb_lat", 128'(sb_at), 128'(2));
    check_val("mid_kw_gap", 128'(kw_at - sb_at), 128'(3));

    // Both requests held from reset: alternating on u_dut, kw only on u_fix.
    @(negedge clk);
    do_reset();
    sb_state_in = {$urandom, $urandom, $urandom, $urandom}; kw_word_in = $urandom;
    f_sb_state_in = sb_state_in; f_kw_word_in = kw_word_in;
    sb_req = 1'b1; kw_req = 1'b1; f_sb_req = 1'b1; f_kw_req = 1'b1;
    n_ord = 0; f_kw_n = 0; f_sb_n = 0;
    for (int k = 0; k < 4; k++) ord[k] = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (kw_ack && n_ord < 4) begin ord[n_ord] = 2; n_ord++; end
      if (sb_ack && n_ord < 4) begin ord[n_ord] = 1; n_ord++; end
      if (f_kw_ack) f_kw_n++;
      if (f_sb_ack) f_sb_n++;
    end
    check_val("rr_order0", 128'(ord[0]), 128'(2));
    check_val("rr_order1", 128'(ord[1]), 128'(1));
    check_val("rr_order2", 128'(ord[2]), 128'(2));
    check_val("rr_order3", 128'(ord[3]), 128'(1));
    check_val("fix_kw_count", 128'(f_kw_n), 128'(7));
    check_val("fix_sb_count", 128'(f_sb_n), 128'(0));
    sb_req = 1'b0; kw_req = 1'b0; f_sb_req = 1'b0; f_kw_req = 1'b0;
    for (int t = 0; t < 6; t++) tick();

    // Reset during SB beat 2 aborts with no ack; re-request afterwards.
    sb_state_in = {$urandom, $urandom, $urandom, $urandom}; sb_req = 1'b1;
    tick(); tick(); tick();
    do_reset();
    sb_state_in = {16{8'hff}}; sb_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("post_rst_ack", 128'(sb_ack), 128'd1);
    check_val("post_rst_data", sb_state_out, {16{8'h16}});
    sb_req = 1'b0;
    tick();

    // Randomized traffic obeying the request protocol.
    for (int n = 0; n < 3000; n++) begin
      if (sb_req) begin
        if (exp_sb_ack()) begin
          if ($urandom_range(1, 0) == 0) sb_req = 1'b0;
          else sb_state_in = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(3, 0) == 0) begin
        sb_req = 1'b1;
        sb_state_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (kw_req) begin
        if (exp_kw_ack()) begin
          if ($urandom_range(1, 0) == 0) kw_req = 1'b0;
          else kw_word_in = $urandom;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        kw_req = 1'b1;
        kw_word_in = ($urandom_range(7, 0) == 0) ? 32'h0 : $urandom;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
